// File: rtl/multi_object_frame_encoder_if.sv
// Signal bundle between the frame encoder, its rotator and the frame SRAM.
// The encoder takes the slave view; the driver of the block (sequencer, rotator, SRAM) takes master.
interface multi_object_frame_encoder_if #(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned ANG_W   = 9,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned PIX_W   = 10
);
    logic                       i_start;
    logic                       i_abort;
    logic [NUM_OBJ-1:0]         i_obj_en;
    logic [NUM_OBJ*ANG_W-1:0]   i_angles;
    logic                       o_rot_start;
    logic [ANG_W-1:0]           o_rot_angle;
    logic [3:0]                 o_rot_obj;
    logic [PIX_W-1:0]           o_rot_pix;
    logic                       i_rot_valid;
    logic [DATA_W-1:0]          i_rot_pixel;
    logic                       i_rot_opaque;
    logic                       o_sram_we;
    logic [ADDR_W-1:0]          o_sram_addr;
    logic [DATA_W-1:0]          o_sram_data;
    logic                       i_sram_ready;
    logic                       o_busy;
    logic                       o_done;

    modport slave (
        input  i_start, i_abort, i_obj_en, i_angles, i_rot_valid, i_rot_pixel, i_rot_opaque,
               i_sram_ready,
        output o_rot_start, o_rot_angle, o_rot_obj, o_rot_pix, o_sram_we, o_sram_addr,
               o_sram_data, o_busy, o_done
    );

    modport master (
        output i_start, i_abort, i_obj_en, i_angles, i_rot_valid, i_rot_pixel, i_rot_opaque,
               i_sram_ready,
        input  o_rot_start, o_rot_angle, o_rot_obj, o_rot_pix, o_sram_we, o_sram_addr,
               o_sram_data, o_busy, o_done
    );
endinterface

// File: rtl/multi_object_frame_encoder.sv
// Walks enabled sprite objects pixel by pixel, requests each rotated pixel and writes the
// opaque ones to SRAM at BASE_ADDR + obj*IMG_SIZE^2 + pix.
module multi_object_frame_encoder #(
    parameter int unsigned NUM_OBJ   = 4,
    parameter int unsigned IMG_SIZE  = 32,
    parameter int unsigned ANG_W     = 9,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    multi_object_frame_encoder_if.slave   bus
);
    localparam int unsigned NPIX  = IMG_SIZE * IMG_SIZE;
    localparam int unsigned PIX_W = (IMG_SIZE > 1) ? 2 * $clog2(IMG_SIZE) : 1;
    localparam int unsigned OBJ_W = $clog2(NUM_OBJ + 1);

    typedef enum logic [2:0] {StIdle, StSeek, StIssue, StWait, StWrite, StDone} state_e;

    state_e                   state_q, state_d;
    logic [NUM_OBJ-1:0]       obj_en_q, obj_en_d;
    logic [NUM_OBJ*ANG_W-1:0] angles_q, angles_d;
    logic [OBJ_W-1:0]         obj_idx_q, obj_idx_d;
    logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     cur_en;
    logic [ANG_W-1:0]         cur_angle;
    logic                     advance;

    // Enable bit and angle of the current object; an index of NUM_OBJ selects nothing.
    always_comb begin
        cur_en    = 1'b0;
        cur_angle = '0;
        for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            if (obj_idx_q == OBJ_W'(k)) begin
                cur_en    = obj_en_q[k];
                cur_angle = angles_q[k*ANG_W +: ANG_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        obj_en_d  = obj_en_q;
        angles_d  = angles_q;
        obj_idx_d = obj_idx_q;
        pix_cnt_d = pix_cnt_q;
        data_d    = data_q;
        advance   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    obj_en_d  = bus.i_obj_en;
                    angles_d  = bus.i_angles;
                    obj_idx_d = '0;
                    pix_cnt_d = '0;
                    state_d   = StSeek;
                end
            end
            StSeek: begin
                if (obj_idx_q == OBJ_W'(NUM_OBJ)) begin
                    state_d = StDone;
                end else if (cur_en) begin
                    pix_cnt_d = '0;
                    state_d   = StIssue;
                end else begin
                    obj_idx_d = obj_idx_q + OBJ_W'(1);
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.i_rot_valid) begin
                    if (bus.i_rot_opaque) begin
                        data_d  = bus.i_rot_pixel;
                        state_d = StWrite;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StWrite: advance = bus.i_sram_ready;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (pix_cnt_q == PIX_W'(NPIX - 1)) begin
                obj_idx_d = obj_idx_q + OBJ_W'(1);
                state_d   = StSeek;
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
                state_d   = StIssue;
            end
        end

        // Abort wins over any rotator or SRAM handshake completing in the same cycle.
        if (bus.i_abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            obj_en_q  <= '0;
            angles_q  <= '0;
            obj_idx_q <= '0;
            pix_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            obj_en_q  <= obj_en_d;
            angles_q  <= angles_d;
            obj_idx_q <= obj_idx_d;
            pix_cnt_q <= pix_cnt_d;
            data_q    <= data_d;
        end
    end

    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_done      = (state_q == StDone);
    assign bus.o_rot_start = (state_q == StIssue);
    assign bus.o_rot_angle = cur_angle;
    assign bus.o_rot_obj   = 4'(obj_idx_q);
    assign bus.o_rot_pix   = pix_cnt_q;
    assign bus.o_sram_we   = (state_q == StWrite);
    assign bus.o_sram_data = data_q;
    // Gated in IDLE so a nonzero BASE_ADDR never shows while the block is at rest.
    assign bus.o_sram_addr = bus.o_busy ?
        (ADDR_W'(BASE_ADDR) + ADDR_W'(obj_idx_q) * ADDR_W'(NPIX) + ADDR_W'(pix_cnt_q)) : '0;
endmodule
